// File: rtl/pcs_block_lock_pkg.sv
// Shared PCS definitions: block-lock state encoding, default window constants
// and small helpers used by the lock FSM, the rx datapath and bench models.
package pcs_block_lock_pkg;

    typedef enum logic [2:0] {
        LOCK_INIT    = 3'd0,
        RESET_CNT    = 3'd1,
        TEST_SH      = 3'd2,
        SLIP         = 3'd3,
        SLIP_WAIT_ST = 3'd4
    } bl_state_e;

    localparam int SH_CNT_MAX_DEF   = 64;
    localparam int SH_INVLD_MAX_DEF = 16;
    localparam int SLIP_WAIT_DEF    = 4;

    localparam logic [7:0] SLIP_CNT_SAT = 8'hFF;

    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == 2'b01) || (hdr == 2'b10);
    endfunction

    // Bits needed to hold 0..max_val; never returns 0 so degenerate parameters still elaborate.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pcs_block_lock.sv
// 66b block-lock FSM: hunts for sync-header alignment by slipping the rx
// gearbox one bit at a time and declares lock after a clean header window.
//
//   state        | meaning
//   LOCK_INIT    | lock cleared, waiting for signal_ok before a new hunt
//   RESET_CNT    | window counters cleared; strobe in this cycle dropped
//   TEST_SH      | counting headers in the current test window
//   SLIP         | one-cycle slip pulse to the gearbox
//   SLIP_WAIT_ST | dropping SLIP_WAIT strobes while the gearbox settles
module pcs_block_lock
    import pcs_block_lock_pkg::*;
#(
    parameter int SH_CNT_MAX   = pcs_block_lock_pkg::SH_CNT_MAX_DEF,
    parameter int SH_INVLD_MAX = pcs_block_lock_pkg::SH_INVLD_MAX_DEF,
    parameter int SLIP_WAIT    = pcs_block_lock_pkg::SLIP_WAIT_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_signal_ok,
    input  logic       i_hdr_valid,
    input  logic [1:0] i_sync_hdr,
    output logic       o_slip,
    output logic       o_block_lock,
    output logic [7:0] o_slip_cnt
);

    localparam int SH_W = cnt_width(SH_CNT_MAX);
    localparam int IV_W = cnt_width(SH_INVLD_MAX);
    localparam int WT_W = cnt_width(SLIP_WAIT);

    localparam logic [SH_W-1:0] SH_MAX_C = SH_W'(SH_CNT_MAX);
    localparam logic [IV_W-1:0] IV_MAX_C = IV_W'(SH_INVLD_MAX);
    localparam logic [WT_W-1:0] WT_MAX_C = WT_W'(SLIP_WAIT);

    bl_state_e       r_state;
    logic [SH_W-1:0] r_sh_cnt;
    logic [IV_W-1:0] r_sh_invld_cnt;
    logic [WT_W-1:0] r_wait_cnt;
    logic            r_block_lock;
    logic            r_slip;
    logic [7:0]      r_slip_cnt;

    bl_state_e       w_state_nxt;
    logic [SH_W-1:0] w_sh_cnt_nxt;
    logic [IV_W-1:0] w_sh_invld_nxt;
    logic [WT_W-1:0] w_wait_nxt;
    logic            w_block_lock_nxt;
    logic            w_slip_nxt;
    logic [7:0]      w_slip_cnt_nxt;

    logic [SH_W-1:0] w_sh_inc;
    logic [IV_W-1:0] w_invld_inc;
    logic [WT_W-1:0] w_wait_inc;
    logic            w_hdr_ok;

    assign w_sh_inc    = r_sh_cnt + SH_W'(1);
    assign w_invld_inc = r_sh_invld_cnt + IV_W'(1);
    assign w_wait_inc  = r_wait_cnt + WT_W'(1);
    assign w_hdr_ok    = hdr_is_valid(i_sync_hdr);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= LOCK_INIT;
            r_sh_cnt       <= '0;
            r_sh_invld_cnt <= '0;
            r_wait_cnt     <= '0;
            r_block_lock   <= 1'b0;
            r_slip         <= 1'b0;
            r_slip_cnt     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_sh_cnt       <= w_sh_cnt_nxt;
            r_sh_invld_cnt <= w_sh_invld_nxt;
            r_wait_cnt     <= w_wait_nxt;
            r_block_lock   <= w_block_lock_nxt;
            r_slip         <= w_slip_nxt;
            r_slip_cnt     <= w_slip_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_sh_cnt_nxt     = r_sh_cnt;
        w_sh_invld_nxt   = r_sh_invld_cnt;
        w_wait_nxt       = r_wait_cnt;
        w_block_lock_nxt = r_block_lock;
        w_slip_nxt       = 1'b0;
        w_slip_cnt_nxt   = r_slip_cnt;

        // Loss of signal outranks whatever header arrives in the same cycle.
        if (!i_signal_ok) begin
            w_state_nxt      = LOCK_INIT;
            w_block_lock_nxt = 1'b0;
            w_sh_cnt_nxt     = '0;
            w_sh_invld_nxt   = '0;
            w_wait_nxt       = '0;
        end else begin
            case (r_state)
                LOCK_INIT: begin
                    w_block_lock_nxt = 1'b0;
                    w_state_nxt      = RESET_CNT;
                end
                RESET_CNT: begin
                    w_sh_cnt_nxt   = '0;
                    w_sh_invld_nxt = '0;
                    w_wait_nxt     = '0;
                    w_state_nxt    = TEST_SH;
                end
                TEST_SH: begin
                    if (i_hdr_valid) begin
                        w_sh_cnt_nxt = w_sh_inc;
                        if (w_hdr_ok) begin
                            if (w_sh_inc == SH_MAX_C) begin
                                w_state_nxt = RESET_CNT;
                                if (r_sh_invld_cnt == '0) begin
                                    w_block_lock_nxt = 1'b1;
                                end
                            end
                        end else begin
                            w_sh_invld_nxt = w_invld_inc;
                            if ((w_invld_inc == IV_MAX_C) || !r_block_lock) begin
                                // Slip is issued here so o_slip is a flop that is high only in SLIP.
                                w_state_nxt      = SLIP;
                                w_slip_nxt       = 1'b1;
                                w_block_lock_nxt = 1'b0;
                                if (r_slip_cnt != SLIP_CNT_SAT) begin
                                    w_slip_cnt_nxt = r_slip_cnt + 8'd1;
                                end
                            end else if (w_sh_inc == SH_MAX_C) begin
                                w_state_nxt = RESET_CNT;
                            end
                        end
                    end
                end
                SLIP: begin
                    w_block_lock_nxt = 1'b0;
                    w_wait_nxt       = '0;
                    w_state_nxt      = (SLIP_WAIT == 0) ? RESET_CNT : SLIP_WAIT_ST;
                end
                SLIP_WAIT_ST: begin
                    if (i_hdr_valid) begin
                        if (w_wait_inc == WT_MAX_C) begin
                            w_wait_nxt  = '0;
                            w_state_nxt = RESET_CNT;
                        end else begin
                            w_wait_nxt = w_wait_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt      = LOCK_INIT;
                    w_block_lock_nxt = 1'b0;
                end
            endcase
        end
    end

    assign o_slip       = r_slip;
    assign o_block_lock = r_block_lock;
    assign o_slip_cnt   = r_slip_cnt;

endmodule

// File: tb/tb_pcs_block_lock.sv
// Bench for pcs_block_lock: directed table, hand-built corner sequences and a
// randomized run against a window/queue-based reference of the lock rules.
module tb_pcs_block_lock;
    import pcs_block_lock_pkg::*;

    localparam int W_MAX  = SH_CNT_MAX_DEF;
    localparam int I_MAX  = SH_INVLD_MAX_DEF;
    localparam int S_WAIT = SLIP_WAIT_DEF;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       signal_ok = 1'b1;
    logic       hdr_valid = 1'b0;
    logic [1:0] sync_hdr = 2'b01;
    logic       slip;
    logic       block_lock;
    logic [7:0] slip_cnt;

    int total = 0;
    int bad = 0;

    // Reference state: headers of the open window, dead cycles still to pass,
    // strobes still to throw away after a slip.
    bit   win[$];
    int   skip_cycles;
    int   ignore_strobes;
    bit   m_lock;
    bit   m_slip;
    int   m_slip_cnt;
    bit   prev_slip;
    bit   slip_seen;

    typedef struct {
        logic       sig;
        logic       hv;
        logic [1:0] hdr;
        logic       e_slip;
        logic       e_lock;
        logic [7:0] e_cnt;
    } vec_t;
    vec_t tbl[12];

    pcs_block_lock dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_signal_ok (signal_ok),
        .i_hdr_valid (hdr_valid),
        .i_sync_hdr  (sync_hdr),
        .o_slip      (slip),
        .o_block_lock(block_lock),
        .o_slip_cnt  (slip_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 25) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        win.delete();
        skip_cycles    = 2;
        ignore_strobes = 0;
        m_lock         = 0;
        m_slip         = 0;
        m_slip_cnt     = 0;
        prev_slip      = 0;
    endtask

    task automatic model_step(input logic sig, input logic hv, input logic [1:0] hdr);
        bit good;
        int nbad;
        m_slip = 0;
        if (!sig) begin
            m_lock = 0;
            win.delete();
            skip_cycles    = 2;
            ignore_strobes = 0;
        end else if (skip_cycles > 0) begin
            skip_cycles--;
        end else if (ignore_strobes > 0) begin
            if (hv) begin
                ignore_strobes--;
                if (ignore_strobes == 0) skip_cycles = 1;
            end
        end else if (hv) begin
            good = (hdr == 2'b01) || (hdr == 2'b10);
            win.push_back(good);
            nbad = 0;
            foreach (win[k]) if (!win[k]) nbad++;
            if (!good && (nbad == I_MAX || !m_lock)) begin
                m_slip = 1;
                m_lock = 0;
                if (m_slip_cnt < 255) m_slip_cnt++;
                win.delete();
                skip_cycles    = 1;
                ignore_strobes = S_WAIT;
            end else if (win.size() == W_MAX) begin
                if (nbad == 0) m_lock = 1;
                win.delete();
                skip_cycles = 1;
            end
        end
    endtask

    // Called at posedge+1; leaves the bench at the next posedge+1.
    task automatic drive_edge(input logic sig, input logic hv, input logic [1:0] hdr);
        signal_ok = sig;
        hdr_valid = hv;
        sync_hdr  = hdr;
        @(posedge clk);
        model_step(sig, hv, hdr);
        #1;
        if (slip) slip_seen = 1;
    endtask

    task automatic cycle(input logic sig, input logic hv, input logic [1:0] hdr);
        drive_edge(sig, hv, hdr);
        chk("slip", int'(slip), int'(m_slip));
        chk("lock", int'(block_lock), int'(m_lock));
        chk("slip_cnt", int'(slip_cnt), m_slip_cnt);
        if (prev_slip) chk("slip_back_to_back", int'(slip), 0);
        prev_slip = slip;
    endtask

    task automatic strobes(input int n, input logic [1:0] hdr);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, hdr);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        chk("rst_slip", int'(slip), 0);
        chk("rst_lock", int'(block_lock), 0);
        chk("rst_slip_cnt", int'(slip_cnt), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin : main
        logic       s;
        logic       hv;
        logic [1:0] h;
        int         inv_pct;

        tbl[0]  = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 8'd1};
        tbl[3]  = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 8'd1};
        tbl[4]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'd1};
        tbl[5]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'd1};
        tbl[6]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'd1};
        tbl[7]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'd1};
        tbl[8]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'd1};
        tbl[9]  = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 8'd2};
        tbl[10] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 8'd2};
        tbl[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'd2};

        slip_seen = 0;
        model_reset();
        #1;
        do_reset();

        // Unlocked: first bad header slips, four strobes dropped, then hunting resumes.
        for (int i = 0; i < 12; i++) begin
            drive_edge(tbl[i].sig, tbl[i].hv, tbl[i].hdr);
            chk($sformatf("tbl%0d_slip", i), int'(slip), int'(tbl[i].e_slip));
            chk($sformatf("tbl%0d_lock", i), int'(block_lock), int'(tbl[i].e_lock));
            chk($sformatf("tbl%0d_cnt", i), int'(slip_cnt), int'(tbl[i].e_cnt));
        end

        // Clean window of 64 good headers.
        do_reset();
        slip_seen = 0;
        cycle(1'b1, 1'b0, 2'b01);
        cycle(1'b1, 1'b0, 2'b01);
        strobes(63, 2'b01);
        chk("lock_before_64", int'(block_lock), 0);
        strobes(1, 2'b01);
        chk("lock_after_64", int'(block_lock), 1);
        chk("no_slip_clean", int'(slip_seen), 0);
        cycle(1'b1, 1'b0, 2'b01);

        // Locked: 15 bad in a window is tolerated, the 16th bad one slips.
        strobes(15, 2'b11);
        strobes(49, 2'b10);
        cycle(1'b1, 1'b0, 2'b01);
        chk("lock_held_15bad", int'(block_lock), 1);
        strobes(15, 2'b00);
        chk("lock_held_mid", int'(block_lock), 1);
        strobes(1, 2'b11);
        chk("slip_on_16th", int'(slip), 1);
        chk("unlock_on_16th", int'(block_lock), 0);

        // Relock, then drop signal_ok together with the 16th bad header.
        cycle(1'b1, 1'b0, 2'b01);
        strobes(S_WAIT, 2'b00);
        cycle(1'b1, 1'b0, 2'b01);
        strobes(64, 2'b01);
        chk("relock", int'(block_lock), 1);
        cycle(1'b1, 1'b0, 2'b01);
        strobes(15, 2'b11);
        cycle(1'b0, 1'b1, 2'b11);
        chk("sigloss_lock", int'(block_lock), 0);
        chk("sigloss_no_slip", int'(slip), 0);
        cycle(1'b1, 1'b0, 2'b01);
        cycle(1'b1, 1'b0, 2'b01);

        // Slip counter saturation.
        do_reset();
        for (int i = 0; i < 300 * (S_WAIT + 3) + 10; i++) cycle(1'b1, 1'b1, 2'b11);
        chk("slip_cnt_sat", int'(slip_cnt), 255);
        do_reset();

        // Reset mid-window discards progress.
        cycle(1'b1, 1'b0, 2'b01);
        cycle(1'b1, 1'b0, 2'b01);
        strobes(30, 2'b01);
        do_reset();
        cycle(1'b1, 1'b0, 2'b01);
        cycle(1'b1, 1'b0, 2'b01);
        strobes(63, 2'b01);
        chk("post_rst_no_early_lock", int'(block_lock), 0);
        strobes(1, 2'b01);
        chk("post_rst_lock", int'(block_lock), 1);

        // Randomized traffic in segments of varying header quality.
        inv_pct = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) begin
                case ($urandom_range(0, 3))
                    0, 1:    inv_pct = 0;
                    2:       inv_pct = 3;
                    default: inv_pct = 40;
                endcase
            end
            if ($urandom_range(0, 1499) == 0) do_reset();
            s  = ($urandom_range(0, 199) != 0);
            hv = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < inv_pct) h = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
            else                                 h = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            cycle(s, hv, h);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcs_block_lock.md
PCS_BLOCK_LOCK -- requirements
Module: pcs_block_lock

Interface
REQ-001 SHALL have parameter SH_CNT_MAX, default 64, meaning headers per test window.
REQ-002 SHALL have parameter SH_INVLD_MAX, default 16, meaning invalid headers per window that force loss of lock.
REQ-003 SHALL have parameter SLIP_WAIT, default 4, meaning header strobes ignored after each slip pulse.
REQ-004 SHALL have port i_clk  input  1  sole clock for all logic.
REQ-005 SHALL have port i_reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_signal_ok  input  1  PMA signal present; low forces re-initialisation.
REQ-007 SHALL have port i_hdr_valid  input  1  strobe: i_sync_hdr holds one 66b-block header this cycle.
REQ-008 SHALL have port i_sync_hdr  input  2  sync header from the rx gearbox.
REQ-009 SHALL have port o_slip  output  1  one-cycle pulse commanding the gearbox to shift alignment by one bit.
REQ-010 SHALL have port o_block_lock  output  1  block alignment achieved.
REQ-011 SHALL have port o_slip_cnt  output  8  saturating count of slip pulses since reset.

Function
REQ-012 SHALL implement states LOCK_INIT, RESET_CNT, TEST_SH, SLIP, SLIP_WAIT_ST.
REQ-013 SHALL treat a header as valid only when i_sync_hdr is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
REQ-014 LOCK_INIT SHALL clear o_block_lock and go to RESET_CNT next cycle.
REQ-015 RESET_CNT SHALL zero sh_cnt and sh_invld_cnt and go to TEST_SH next cycle; a strobe arriving in this cycle is discarded.
REQ-016 In TEST_SH, cycles without i_hdr_valid SHALL hold all counters and state.
REQ-017 Valid strobe in TEST_SH: sh_cnt increments; if new sh_cnt == SH_CNT_MAX and sh_invld_cnt == 0, o_block_lock SHALL set next cycle and state goes to RESET_CNT.
REQ-018 Valid strobe with new sh_cnt == SH_CNT_MAX and sh_invld_cnt > 0 SHALL go to RESET_CNT leaving o_block_lock unchanged.
REQ-019 Invalid strobe in TEST_SH: sh_cnt and sh_invld_cnt increment; if new sh_invld_cnt == SH_INVLD_MAX or o_block_lock == 0, state SHALL go to SLIP.
REQ-020 Invalid strobe not meeting REQ-019 with new sh_cnt == SH_CNT_MAX SHALL go to RESET_CNT, lock retained.
REQ-021 SLIP SHALL last exactly one cycle: o_slip = 1, o_block_lock = 0, o_slip_cnt increments saturating at 255, then SLIP_WAIT_ST.
REQ-022 SLIP_WAIT_ST SHALL count SLIP_WAIT i_hdr_valid strobes, discarding their headers, then go to RESET_CNT.
REQ-023 o_slip SHALL be registered and never high for two consecutive cycles.
REQ-024 i_signal_ok low SHALL, from any state, go to LOCK_INIT on the next edge, clear o_block_lock and suppress o_slip; i_signal_ok has priority over header evaluation in the same cycle.
REQ-025 Counters SHALL be sized $clog2(SH_CNT_MAX+1) and $clog2(SH_INVLD_MAX+1) bits and never wrap.
REQ-026 Latency from the decisive header strobe to o_block_lock or o_slip change SHALL be one cycle.

Reset
REQ-027 Asserting i_reset_n low SHALL immediately force state LOCK_INIT, o_slip = 0, o_block_lock = 0, o_slip_cnt = 0, all internal counters 0.
REQ-028 Reset asserted mid-window or mid-SLIP_WAIT_ST SHALL discard all progress; after release the FSM restarts from LOCK_INIT.

Structure
REQ-029 The state enum and the default constants (64, 16, 4) SHALL live in the shared PCS package for reuse by the rx datapath and bench models.
REQ-030 The block SHALL be a single module with no sub-modules; counters and FSM are inline.

Verification
REQ-031 Reset release, i_signal_ok = 1, 64 strobes of 2'b01 -> o_block_lock = 1 one cycle after the 64th strobe; o_slip never asserted.
REQ-032 Unlocked, first strobe 2'b11 -> o_slip pulses once next cycle, o_slip_cnt = 1; the next 4 strobes are ignored, then counting restarts.
REQ-033 Locked, 15 invalid among 64 strobes -> lock held; 16 invalid within one window -> o_slip pulse and o_block_lock = 0 on the cycle after the 16th.
REQ-034 Locked, i_signal_ok dropped concurrently with the 16th invalid strobe -> o_block_lock = 0, no o_slip, state LOCK_INIT.
REQ-035 300 forced slips -> o_slip_cnt saturates at 255.
REQ-036 i_reset_n asserted after 30 valid strobes, released, 64 valid strobes -> lock only after the full post-reset 64.
